// File: rtl/top_level.sv
// Streaming NEO spike detector: on detection, captures the windowed peak and
// publishes a pulse, amplitude/polarity class, wrapping count and peak sample.
module top_level #(
    parameter int NEO_THRESH  = 40000,
    parameter int LARGE_AMP   = 1000,
    parameter int WINDOW      = 16,
    parameter int REFRACT_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] data_in,
    output logic        [31:0] event_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_REFRACT = 2'd2;

    localparam int CNT_W = $clog2(WINDOW);
    localparam int RC_W  = (REFRACT_LEN > 1) ? $clog2(REFRACT_LEN) : 1;

    localparam logic signed [33:0] THRESH = 34'(NEO_THRESH);
    localparam logic        [16:0] LARGE  = 17'(LARGE_AMP);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [RC_W-1:0]    RC_LAST  = RC_W'(REFRACT_LEN - 1);

    // 17-bit magnitude so that -32768 maps to 32768 without wrapping
    function automatic logic [16:0] mag(input logic signed [15:0] v);
        logic signed [16:0] e;
        e = {v[15], v};
        mag = e[16] ? 17'(-e) : 17'(e);
    endfunction

    logic signed [15:0] r_x0, r_x1, r_x2;
    logic signed [15:0] r_peak;
    logic        [1:0]  r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RC_W-1:0]    r_rcnt;
    logic        [12:0] r_count;
    logic        [31:0] r_event;

    logic signed [33:0] w_x0e, w_x1e, w_x2e;
    logic signed [33:0] w_psi;
    logic               w_det;
    logic        [16:0] w_mag_x0, w_mag_x1, w_mag_pk, w_mag_next;
    logic signed [15:0] w_peak_next;

    assign w_x0e = {{18{r_x0[15]}}, r_x0};
    assign w_x1e = {{18{r_x1[15]}}, r_x1};
    assign w_x2e = {{18{r_x2[15]}}, r_x2};

    // Full-precision NEO energy; 34 bits hold every product difference exactly
    assign w_psi = (w_x1e * w_x1e) - (w_x0e * w_x2e);
    assign w_det = (w_psi > THRESH);

    assign w_mag_x0 = mag(r_x0);
    assign w_mag_x1 = mag(r_x1);
    assign w_mag_pk = mag(r_peak);

    // Strict compare keeps the earlier sample on magnitude ties
    assign w_peak_next = (w_mag_x0 > w_mag_pk) ? r_x0 : r_peak;
    assign w_mag_next  = mag(w_peak_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0    <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_peak  <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_count <= '0;
            r_event <= '0;
        end else begin
            r_x2       <= r_x1;
            r_x1       <= r_x0;
            r_x0       <= data_in;
            r_event[31] <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_peak <= (w_mag_x0 > w_mag_x1) ? r_x0 : r_x1;
                    if (w_det) begin
                        r_state <= S_CAPTURE;
                        r_cnt   <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_peak <= w_peak_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_event <= {1'b1,
                                    (w_mag_next >= LARGE),
                                    w_peak_next[15],
                                    r_count + 13'd1,
                                    w_peak_next};
                        r_count <= r_count + 13'd1;
                        r_state <= S_REFRACT;
                        r_rcnt  <= '0;
                    end
                end
                S_REFRACT: begin
                    if (r_rcnt == RC_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign event_out = r_event;

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level: directed and random segments on one instance,
// count-wrap run on a short-window instance in parallel.
module tb_top_level;

    localparam int W  = 16;
    localparam int R  = 32;
    localparam int TH = 40000;
    localparam int LG = 1000;
    localparam int WB = 2;
    localparam int RB = 1;
    localparam int N_WRAP = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_a = 1'b1;
    logic               rst_b = 1'b1;
    logic signed [15:0] din_a = '0;
    logic signed [15:0] din_b = '0;
    logic        [31:0] eo_a;
    logic        [31:0] eo_b;

    top_level #(.NEO_THRESH(TH), .LARGE_AMP(LG), .WINDOW(W), .REFRACT_LEN(R)) u_dut_a (
        .clk(clk), .rst(rst_a), .data_in(din_a), .event_out(eo_a));

    top_level #(.NEO_THRESH(TH), .LARGE_AMP(LG), .WINDOW(WB), .REFRACT_LEN(RB)) u_dut_b (
        .clk(clk), .rst(rst_b), .data_in(din_b), .event_out(eo_b));

    typedef struct {
        int          edge_no;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   seg[$];
    int   dir_trig[$];
    logic [31:0] dir_word[$];

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    logic rst_a_q = 1'b1;
    logic rst_b_q = 1'b1;

    always @(posedge clk) begin
        edge_n  <= edge_n + 1;
        rst_a_q <= rst_a;
        rst_b_q <= rst_b;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at edge %0d", name, got, exp, edge_n);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint sv(input int i);
        return (i < 0) ? 64'sd0 : longint'(seg[i]);
    endfunction

    // Event list straight from the rules: trigger sample i is x1 when detection
    // happens, which is the edge consuming sample i+2; the report lands W edges on.
    function automatic void model_push(input int base);
        int n, i, cnt, pk;
        longint p;
        logic [31:0] w;
        n = seg.size();
        i = 0;
        cnt = 0;
        while (i + 3 + W <= n) begin
            p = sv(i) * sv(i) - sv(i + 1) * sv(i - 1);
            if (p > longint'(TH)) begin
                pk = seg[i];
                for (int k = i + 1; k <= i + W + 1; k++)
                    if (iabs(seg[k]) > iabs(pk)) pk = seg[k];
                cnt++;
                w = {1'b1, 1'(iabs(pk) >= LG), 1'(pk < 0), 13'(cnt), 16'(pk)};
                exp_q.push_back('{base + 3 + i + W, w});
                i += W + R + 1;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic run_seg_a(input bit use_model);
        int base;
        @(negedge clk);
        rst_a = 1'b1;
        din_a = '0;
        @(negedge clk);
        rst_a = 1'b0;
        base = edge_n;
        if (use_model) model_push(base);
        else for (int k = 0; k < dir_trig.size(); k++)
            exp_q.push_back('{base + 3 + dir_trig[k] + W, dir_word[k]});
        for (int j = 0; j < seg.size(); j++) begin
            if (j > 0) @(negedge clk);
            din_a = 16'(seg[j]);
        end
    endtask

    task automatic zero_seg(input int n);
        seg.delete();
        dir_trig.delete();
        dir_word.delete();
        for (int j = 0; j < n; j++) seg.push_back(0);
    endtask

    task automatic expect_at(input int trig, input logic [31:0] word);
        dir_trig.push_back(trig);
        dir_word.push_back(word);
    endtask

    // Monitor A: pops on every pulse, otherwise checks held bits and missed reports
    logic [31:0] hold_a = '0;
    exp_t        e_a;
    always @(negedge clk) begin
        if (rst_a_q) begin
            check("reset_clear", eo_a, 32'h0);
            hold_a = '0;
        end else if (eo_a[31]) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got %h expected no pulse at edge %0d", eo_a, edge_n);
            end else begin
                e_a = exp_q.pop_front();
                check("event_word", eo_a, e_a.word);
                check("event_edge", edge_n, e_a.edge_no);
                hold_a = {1'b0, e_a.word[30:0]};
            end
        end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_n) begin
            e_a = exp_q.pop_front();
            check("missing_event", eo_a, e_a.word);
            hold_a = {1'b0, e_a.word[30:0]};
        end else begin
            check("hold", eo_a, hold_a);
        end
    end

    // Monitor B: every report is the k-th +300 impulse with a 13-bit wrapping count
    int          pulses_b = 0;
    logic [31:0] last_b   = '0;
    always @(negedge clk) begin
        if (!rst_b_q && eo_b[31]) begin
            pulses_b++;
            check("wrap_word", eo_b, {3'b100, 13'(pulses_b), 16'd300});
            last_b = eo_b;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion at edge %0d", edge_n);
        $fatal(1, "bench timeout");
    end

    initial begin
        fork
            begin : stim_a
                int n, v;
                logic signed [15:0] t;
                // quiet stream with a reset in the middle
                zero_seg(500); run_seg_a(1'b0);
                zero_seg(500); run_seg_a(1'b0);
                zero_seg(60); seg[10] = 300; expect_at(10, 32'h8001012C); run_seg_a(1'b0);
                zero_seg(60); seg[10] = -2000; expect_at(10, 32'hE001F830); run_seg_a(1'b0);
                zero_seg(130);
                seg[10] = 300; seg[15] = 700; seg[48] = 500; seg[68] = 500;
                expect_at(10, 32'h800102BC); expect_at(68, 32'h800201F4); run_seg_a(1'b0);
                zero_seg(60); seg[10] = 200; run_seg_a(1'b0);
                zero_seg(60); seg[10] = -1000; expect_at(10, 32'hE001FC18); run_seg_a(1'b0);
                zero_seg(60); seg[10] = 500; seg[13] = -500; expect_at(10, 32'h800101F4); run_seg_a(1'b0);
                // reset lands mid-capture, then a fresh event counts from 1
                zero_seg(18); seg[10] = 300; run_seg_a(1'b0);
                zero_seg(60); seg[10] = 300; expect_at(10, 32'h8001012C); run_seg_a(1'b0);
                for (int s = 0; s < 40; s++) begin
                    seg.delete();
                    n = $urandom_range(40, 300);
                    for (int j = 0; j < n; j++) begin
                        v = int'($urandom_range(0, 80)) - 40;
                        if ($urandom_range(0, 24) == 0) begin
                            case ($urandom_range(0, 6))
                                0, 1: begin t = 16'($urandom()); v = int'(t); end
                                2: v = 1000;
                                3: v = -1000;
                                4: v = ($urandom_range(0, 1) == 1) ? 999 : -999;
                                5: v = -32768;
                                default: v = ($urandom_range(0, 1) == 1) ? 201 : -200;
                            endcase
                        end
                        seg.push_back(v);
                    end
                    run_seg_a(1'b1);
                end
                zero_seg(40); run_seg_a(1'b1);
            end
            begin : stim_b
                @(negedge clk);
                rst_b = 1'b1;
                din_b = '0;
                @(negedge clk);
                rst_b = 1'b0;
                for (int j = 0; j < 10; j++) begin din_b = '0; @(negedge clk); end
                for (int k = 0; k < N_WRAP; k++) begin
                    din_b = 16'sd300;
                    @(negedge clk);
                    din_b = '0;
                    repeat (4) @(negedge clk);
                end
                repeat (30) @(negedge clk);
                check("wrap_pulse_count", pulses_b, N_WRAP);
                check("wrap_last_count", 32'(last_b[28:16]), 32'h0);
                check("wrap_hold", eo_b, 32'h0000012C);
            end
        join
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
